// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared pipeline types and defaults for the MEM/WB stage
package mem_wb_stage_pkg;

    localparam int DBITS_DEF               = 32;
    localparam int REG_INDEX_BIT_WIDTH_DEF = 4;
    localparam int MEM_TIMEOUT_DEF         = 16;

    typedef enum logic [1:0] {
        MUL_ALU = 2'd0,
        MUL_MEM = 2'd1,
        MUL_PC4 = 2'd2,
        MUL_RSV = 2'd3
    } mulsel_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WAIT_WR = 2'd2
    } state_e;

endpackage

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access and register writeback with load/store handshake and timeout
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DBITS               = DBITS_DEF,
    parameter int REG_INDEX_BIT_WIDTH = REG_INDEX_BIT_WIDTH_DEF,
    parameter int MEM_TIMEOUT         = MEM_TIMEOUT_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] inWrtIndex,
    input  logic                           inRegWrEn,
    input  logic [1:0]                     inMulSel,
    input  logic [DBITS-1:0]               inAluOut,
    input  logic [DBITS-1:0]               inData2Out,
    input  logic [DBITS-1:0]               inPC,
    input  logic                           inIsLoad,
    input  logic                           inIsStore,
    output logic                           memReq,
    output logic                           memWe,
    output logic [DBITS-1:0]               memAddr,
    output logic [DBITS-1:0]               memWdata,
    input  logic                           memAck,
    input  logic [DBITS-1:0]               memRdata,
    output logic                           rfWrEn,
    output logic [REG_INDEX_BIT_WIDTH-1:0] rfWrIndex,
    output logic [DBITS-1:0]               rfWrData,
    output logic                           memBusy,
    output logic                           memErr
);

    localparam int            CW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    state_e                         state_q;
    logic [CW-1:0]                  cnt_q;
    logic [DBITS-1:0]               addr_q;
    logic [DBITS-1:0]               wdata_q;
    logic [REG_INDEX_BIT_WIDTH-1:0] idx_q;
    logic                           wen_q;
    logic                           rf_en_q;
    logic [REG_INDEX_BIT_WIDTH-1:0] rf_idx_q;
    logic [DBITS-1:0]               rf_data_q;
    logic                           err_q;
    logic [DBITS-1:0]               wb_data_d;

    // writeback source mux; the reserved encoding falls back to the ALU result
    always_comb begin
        wb_data_d = (mulsel_e'(inMulSel) == MUL_MEM) ? memRdata :
                    (mulsel_e'(inMulSel) == MUL_PC4) ? inPC + DBITS'(4) : inAluOut;
    end

    // stage FSM: accept ops in IDLE, hold the memory request until ack or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            wen_q     <= 1'b0;
            rf_en_q   <= 1'b0;
            rf_idx_q  <= '0;
            rf_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rf_en_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (inIsLoad) begin
                        state_q <= WAIT_RD;
                        addr_q  <= inAluOut;
                        idx_q   <= inWrtIndex;
                        wen_q   <= inRegWrEn;
                        cnt_q   <= '0;
                    end else if (inIsStore) begin
                        state_q <= WAIT_WR;
                        addr_q  <= inAluOut;
                        wdata_q <= inData2Out;
                        cnt_q   <= '0;
                    end else begin
                        rf_en_q   <= inRegWrEn;
                        rf_idx_q  <= inWrtIndex;
                        rf_data_q <= wb_data_d;
                    end
                end
                WAIT_RD, WAIT_WR: begin
                    if (memAck) begin
                        state_q <= IDLE;
                        if (state_q == WAIT_RD) begin
                            rf_en_q   <= wen_q;
                            rf_idx_q  <= idx_q;
                            rf_data_q <= memRdata;
                        end
                    end else if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign memReq    = (state_q != IDLE);
    assign memBusy   = (state_q != IDLE);
    assign memWe     = (state_q == WAIT_WR);
    assign memAddr   = addr_q;
    assign memWdata  = wdata_q;
    assign rfWrEn    = rf_en_q;
    assign rfWrIndex = rf_idx_q;
    assign rfWrData  = rf_data_q;
    assign memErr    = err_q;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DBITS, 32, datapath width.
REQ-002 Parameter REG_INDEX_BIT_WIDTH, 4, register index width.
REQ-003 Parameter MEM_TIMEOUT, 16, maximum cycles waiting for memAck.
REQ-004 clk  in  1  clock, rising-edge active.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 inWrtIndex  in  4  destination register index from the EX/MEM pipeline register.
REQ-007 inRegWrEn  in  1  register write enable from the EX/MEM pipeline register.
REQ-008 inMulSel  in  2  writeback source select.
REQ-009 inAluOut  in  32  ALU result; also the memory address for loads and stores.
REQ-010 inData2Out  in  32  store data.
REQ-011 inPC  in  32  PC of the instruction.
REQ-012 inIsLoad  in  1  load marker.
REQ-013 inIsStore  in  1  store marker.
REQ-014 memReq  out  1  data-memory request.
REQ-015 memWe  out  1  data-memory write enable (1 = store).
REQ-016 memAddr  out  32  data-memory address.
REQ-017 memWdata  out  32  data-memory write data.
REQ-018 memAck  in  1  data-memory completion strobe.
REQ-019 memRdata  in  32  load data, valid when memAck=1.
REQ-020 rfWrEn  out  1  register-file write enable.
REQ-021 rfWrIndex  out  4  register-file write index.
REQ-022 rfWrData  out  32  register-file write data.
REQ-023 memBusy  out  1  upstream hold request.
REQ-024 memErr  out  1  one-cycle pulse indicating a memory timeout.

Function
REQ-025 States SHALL be IDLE, WAIT_RD and WAIT_WR.
REQ-026 memBusy SHALL equal (state != IDLE); inputs SHALL be ignored while memBusy=1, and upstream holds its outputs during that time.
REQ-027 inMulSel encoding: 0 = inAluOut, 1 = memory data, 2 = inPC+4 (32-bit wrap), 3 = reserved, treated as inAluOut.
REQ-028 Non-memory op in IDLE: rfWrEn <= inRegWrEn, rfWrIndex <= inWrtIndex and rfWrData <= the selected source at the next edge (latency 1).
REQ-029 inIsLoad=1 in IDLE: capture address, index and inRegWrEn; go to WAIT_RD; rfWrEn <= 0.
REQ-030 inIsStore=1 (inIsLoad=0) in IDLE: capture address and data; go to WAIT_WR; rfWrEn <= 0.
REQ-031 inIsLoad and inIsStore both 1: the op SHALL be treated as a load.
REQ-032 memReq SHALL be 1 exactly while in a WAIT state.
REQ-033 memWe SHALL be 1 exactly while in WAIT_WR.
REQ-034 memAddr and memWdata SHALL hold the captured values throughout a WAIT state.
REQ-035 memAck=1 in WAIT_RD: rfWrEn <= captured inRegWrEn, rfWrData <= memRdata and rfWrIndex <= captured index at that edge; go to IDLE (load latency = ack cycle + 1).
REQ-036 memAck=1 in WAIT_WR: go to IDLE with no register write.
REQ-037 memAck SHALL be ignored in IDLE.
REQ-038 A wait counter SHALL clear on WAIT entry and increment each WAIT cycle without ack.
REQ-039 When the counter reaches MEM_TIMEOUT-1 without ack: go to IDLE, pulse memErr for 1 cycle, no register write.
REQ-040 rfWrEn SHALL be a single-cycle pulse per completing instruction.
REQ-041 Index 0 SHALL be passed through unfiltered.
REQ-042 Back-to-back ops SHALL be accepted on the first IDLE cycle after returning from WAIT, with no bubble.

Reset
REQ-043 On reset: state=IDLE, counter=0, memReq=0, memWe=0, memAddr=0, memWdata=0, rfWrEn=0, rfWrIndex=0, rfWrData=0, memErr=0, memBusy=0.
REQ-044 Reset during a WAIT state SHALL abort the transaction (memReq=0 after the reset edge) with no register write and no memErr.

Structure
REQ-045 The mulsel encodings, the state enumeration, DBITS and REG_INDEX_BIT_WIDTH defaults SHALL reside in the shared pipeline package.
REQ-046 The block SHALL be a single module with no sub-module; the writeback mux SHALL be inline.

Verification
REQ-047 ALU op: inMulSel=0, inAluOut=0x1234, inWrtIndex=5, inRegWrEn=1 -> next cycle rfWrEn=1, rfWrIndex=5, rfWrData=0x1234.
REQ-048 JAL link: inMulSel=2, inPC=0xFFFFFFFC -> rfWrData=0x00000000 (wrap).
REQ-049 Load: inIsLoad=1, inAluOut=0x40, index 3, ack after 3 cycles with memRdata=0xDEADBEEF -> memReq/memBusy high for 3 cycles, memAddr=0x40, then rfWrEn=1 to r3 with 0xDEADBEEF.
REQ-050 Store: inIsStore=1, inAluOut=0x80, inData2Out=0x55 -> memWe=1, memWdata=0x55 until ack; rfWrEn stays 0 throughout.
REQ-051 Timeout: load with no ack -> after 16 WAIT cycles memErr pulses once, state returns to IDLE, no register write.
REQ-052 Reset asserted in the 2nd WAIT_RD cycle, then ack -> memReq=0 after the reset edge; ack ignored; no rfWrEn.
